// File: rtl/uart_frame_parser.sv
// Frame parser for a byte stream from a UART receiver: SYNC, ADDR, LEN, payload, CHK.
// A frame whose ADDR..CHK bytes sum to zero (mod 256) is replayed as LEN register writes.
module uart_frame_parser #(
  parameter logic [7:0]        SYNC    = 8'hA5,
  parameter int                MAXLEN  = 16,
  parameter int                TOUT_N  = 16,
  parameter logic [TOUT_N-1:0] TIMEOUT = TOUT_N'(50000)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] RxData,
  input  logic       RxReady,
  output logic       RxAck,
  output logic [7:0] WrAddr,
  output logic [7:0] WrData,
  output logic       WrEn,
  output logic       FrameOK,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int AW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int CW    = $clog2(MAXLEN + 1);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_WRITE
  } state_t;

  state_t            state_q;
  logic              rx_ack_q;
  logic              rx_low_q;
  logic              wr_en_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic [7:0]        base_q;
  logic [7:0]        chk_q;
  logic [7:0]        wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     idx_q;
  logic [TOUT_N-1:0] tout_q;
  logic [7:0]        buf_q [DEPTH];

  logic              accept_d;
  logic              len_ok_d;
  logic              tout_act_d;
  logic              tout_exp_d;
  logic [7:0]        chk_d;
  logic [7:0]        rd_data_d;
  logic [7:0]        wr_addr_d;

  // A byte is taken only once the receiver has dropped RxReady since the last ack.
  assign accept_d   = RxReady && !rx_ack_q && rx_low_q && (state_q != S_WRITE);
  assign chk_d      = chk_q + RxData;
  assign len_ok_d   = (RxData != 8'd0) && (RxData <= 8'(MAXLEN));
  assign tout_act_d = state_q inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHECK};
  assign tout_exp_d = tout_act_d && !accept_d && (tout_q <= TOUT_N'(1));
  assign rd_data_d  = buf_q[idx_q[AW-1:0]];
  assign wr_addr_d  = base_q + 8'(idx_q);

  assign RxAck    = rx_ack_q;
  assign WrAddr   = wr_addr_q;
  assign WrData   = wr_data_q;
  assign WrEn     = wr_en_q;
  assign FrameOK  = frame_ok_q;
  assign FrameErr = frame_err_q;
  assign Busy     = (state_q != S_IDLE);

  always_ff @(posedge Clk) begin
    if (accept_d && (state_q == S_PAYLOAD)) begin
      buf_q[idx_q[AW-1:0]] <= RxData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rx_ack_q    <= 1'b0;
      rx_low_q    <= 1'b1;
      wr_en_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      base_q      <= 8'd0;
      chk_q       <= 8'd0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      len_q       <= '0;
      idx_q       <= '0;
      tout_q      <= '0;
    end else begin
      rx_ack_q    <= accept_d;
      wr_en_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (accept_d) begin
        rx_low_q <= 1'b0;
      end else if (!RxReady) begin
        rx_low_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (accept_d && (RxData == SYNC)) begin
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (accept_d) begin
            base_q  <= RxData;
            chk_q   <= RxData;
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (accept_d) begin
            if (len_ok_d) begin
              len_q   <= RxData[CW-1:0];
              chk_q   <= chk_d;
              idx_q   <= '0;
              state_q <= S_PAYLOAD;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept_d) begin
            chk_q <= chk_d;
            idx_q <= idx_q + CW'(1);
            if (idx_q == len_q - CW'(1)) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept_d) begin
            if (chk_d == 8'd0) begin
              // First write goes out in the very next cycle, straight from buffer slot 0.
              wr_en_q    <= 1'b1;
              wr_addr_q  <= base_q;
              wr_data_q  <= buf_q[AW'(0)];
              frame_ok_q <= (len_q == CW'(1));
              idx_q      <= CW'(1);
              state_q    <= S_WRITE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (idx_q != len_q) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= rd_data_d;
            frame_ok_q <= (idx_q == len_q - CW'(1));
            idx_q      <= idx_q + CW'(1);
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // An accepted byte in the expiry cycle reloads the counter instead of timing out.
      if (tout_exp_d) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
        tout_q      <= '0;
      end else if (accept_d) begin
        tout_q <= TIMEOUT;
      end else if (tout_act_d) begin
        tout_q <= tout_q - TOUT_N'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: expected writes are queued as frames are sent
// and popped as WrEn appears; pulse timing is checked relative to RxAck cycles.
module tb_uart_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       RxReady = 1'b0;
  logic [7:0] RxData = 8'h00;
  logic       RxAck;
  logic [7:0] WrAddr;
  logic [7:0] WrData;
  logic       WrEn;
  logic       FrameOK;
  logic       FrameErr;
  logic       Busy;

  uart_frame_parser #(
    .SYNC   (SYNC),
    .MAXLEN (16),
    .TOUT_N (16),
    .TIMEOUT(16'd20)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .RxData  (RxData),
    .RxReady (RxReady),
    .RxAck   (RxAck),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .WrEn    (WrEn),
    .FrameOK (FrameOK),
    .FrameErr(FrameErr),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int last_ack_cyc = 0;
  int last_err_cyc = 0;

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input logic l);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score whatever the DUT produced in it.
  task automatic tick();
    wr_t e;
    @(negedge Clk);
    cyc++;
    if (RxAck) begin
      ack_cnt++;
      last_ack_cyc = cyc;
    end
    if (FrameErr) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (FrameOK) ok_cnt++;
    if (FrameOK || FrameErr) begin
      checks++;
      if (FrameOK && FrameErr) begin
        errors++;
        $display("FAIL pulse_exclusive cyc=%0d got ok=1 err=1 required only one", cyc);
      end
    end
    if (WrEn) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h required no write", cyc, WrAddr, WrData);
      end else begin
        e = exp_q.pop_front();
        $display("write cyc=%0d addr=%h data=%h ok=%b", cyc, WrAddr, WrData, FrameOK);
        if (WrAddr !== e.addr || WrData !== e.data || FrameOK !== e.last || Busy !== 1'b1) begin
          errors++;
          $display("FAIL write cyc=%0d got addr=%h data=%h ok=%b busy=%b required addr=%h data=%h ok=%b busy=1",
                   cyc, WrAddr, WrData, FrameOK, Busy, e.addr, e.data, e.last);
        end
      end
    end else if (FrameOK) begin
      checks++;
      errors++;
      $display("FAIL ok_without_write cyc=%0d got FrameOK=1 WrEn=0 required FrameOK only with final WrEn", cyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    RxData  = b;
    RxReady = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = RxAck;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout byte=%h got no RxAck required RxAck within 40 cycles", b);
    end
    RxReady = 1'b0;
    tick();
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({RxAck, WrEn, FrameOK, FrameErr, Busy, WrAddr, WrData} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b we=%b ok=%b err=%b busy=%b addr=%h data=%h required all 0",
               RxAck, WrEn, FrameOK, FrameErr, Busy, WrAddr, WrData);
    end
    RxData  = 8'h3C;
    RxReady = 1'b1;
    Reset   = 1'b0;
    tick();
    checks++;
    if (RxAck !== 1'b1) begin
      errors++;
      $display("FAIL first_accept got RxAck=%b required 1", RxAck);
    end
    RxReady = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0 || err_cnt != 0) begin
      errors++;
      $display("FAIL discard_idle got busy=%b errs=%0d required busy=0 errs=0", Busy, err_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    int ok0, err0, ack0;
    ok0 = ok_cnt; err0 = err_cnt; ack0 = ack_cnt;
    push_wr(8'h10, 8'h11, 1'b0);
    push_wr(8'h11, 8'h22, 1'b1);
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    send_all();
    drain(6);
    checks++;
    if (ok_cnt - ok0 != 1 || err_cnt != err0 || ack_cnt - ack0 != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_frame got ok=%0d err=%0d acks=%0d pending=%0d required ok=1 err=0 acks=6 pending=0",
               ok_cnt - ok0, err_cnt - err0, ack_cnt - ack0, exp_q.size());
    end
    $display("test_good_frame done");
  endtask

  task automatic test_bad_checksum();
    int err0, wr0;
    err0 = err_cnt; wr0 = wr_cnt;
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC};
    send_all();
    drain(4);
    checks++;
    if (err_cnt - err0 != 1 || last_err_cyc != last_ack_cyc || wr_cnt != wr0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_checksum got errs=%0d err_cyc=%0d ack_cyc=%0d writes=%0d busy=%b required errs=1 err_cyc=ack_cyc writes=0 busy=0",
               err_cnt - err0, last_err_cyc, last_ack_cyc, wr_cnt - wr0, Busy);
    end
    $display("test_bad_checksum done");
  endtask

  task automatic test_addr_wrap();
    int ok0;
    ok0 = ok_cnt;
    push_wr(8'hFF, 8'h01, 1'b0);
    push_wr(8'h00, 8'h02, 1'b1);
    tx_q = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFC};
    send_all();
    drain(4);
    checks++;
    if (ok_cnt - ok0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL addr_wrap got ok=%0d pending=%0d required ok=1 pending=0", ok_cnt - ok0, exp_q.size());
    end
    $display("test_addr_wrap done");
  endtask

  task automatic test_bad_len();
    int err0;
    logic [7:0] lb;
    for (int t = 0; t < 2; t++) begin
      err0 = err_cnt;
      lb = (t == 0) ? 8'h00 : 8'h11;
      tx_q = '{8'hA5, 8'h10};
      tx_q.push_back(lb);
      send_all();
      drain(2);
      checks++;
      if (err_cnt - err0 != 1 || last_err_cyc != last_ack_cyc || Busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_len len=%h got errs=%0d err_cyc=%0d ack_cyc=%0d busy=%b required errs=1 err_cyc=ack_cyc busy=0",
                 lb, err_cnt - err0, last_err_cyc, last_ack_cyc, Busy);
      end
    end
    $display("test_bad_len done");
  endtask

  task automatic test_timeout();
    bit got;
    int err0, ok0, a10;
    got = 1'b0;
    tx_q = '{8'hA5, 8'h10};
    send_all();
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = FrameErr;
    end
    checks++;
    if (!got || last_err_cyc - last_ack_cyc != 20 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_latency got seen=%b delay=%0d busy=%b required seen=1 delay=20 busy=0",
               got, last_err_cyc - last_ack_cyc, Busy);
    end
    err0 = err_cnt; ok0 = ok_cnt;
    tx_q = '{8'hA5, 8'h10};
    send_all();
    a10 = last_ack_cyc;
    repeat (18) tick();
    send_byte(8'h02);
    checks++;
    if (last_ack_cyc - a10 != 20 || err_cnt != err0) begin
      errors++;
      $display("FAIL timeout_edge_accept got delay=%0d errs=%0d required delay=20 errs=0",
               last_ack_cyc - a10, err_cnt - err0);
    end
    push_wr(8'h10, 8'h11, 1'b0);
    push_wr(8'h11, 8'h22, 1'b1);
    tx_q = '{8'h11, 8'h22, 8'hBB};
    send_all();
    drain(4);
    checks++;
    if (ok_cnt - ok0 != 1 || err_cnt != err0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_resume got ok=%0d errs=%0d pending=%0d required ok=1 errs=0 pending=0",
               ok_cnt - ok0, err_cnt - err0, exp_q.size());
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_write();
    int ok0, err0, wr0;
    ok0 = ok_cnt; err0 = err_cnt; wr0 = wr_cnt;
    push_wr(8'h20, 8'h01, 1'b0);
    push_wr(8'h21, 8'h02, 1'b0);
    push_wr(8'h22, 8'h03, 1'b0);
    tx_q = '{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    send_all();
    RxData  = 8'hD2;
    RxReady = 1'b1;
    tick();
    checks++;
    if (RxAck !== 1'b1) begin
      errors++;
      $display("FAIL chk_accept got RxAck=%b required 1", RxAck);
    end
    RxReady = 1'b0;
    tick();
    tick();
    checks++;
    if (WrEn !== 1'b1 || WrAddr !== 8'h22) begin
      errors++;
      $display("FAIL third_write got we=%b addr=%h required we=1 addr=22", WrEn, WrAddr);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({RxAck, WrEn, FrameOK, FrameErr, Busy, WrAddr, WrData} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_write got ack=%b we=%b ok=%b err=%b busy=%b addr=%h data=%h required all 0",
               RxAck, WrEn, FrameOK, FrameErr, Busy, WrAddr, WrData);
    end
    repeat (3) tick();
    Reset = 1'b0;
    drain(20);
    checks++;
    if (wr_cnt - wr0 != 3 || err_cnt != err0 || ok_cnt != ok0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_quiet got writes=%0d errs=%0d oks=%0d pending=%0d required writes=3 errs=0 oks=0 pending=0",
               wr_cnt - wr0, err_cnt - err0, ok_cnt - ok0, exp_q.size());
    end
    push_wr(8'h30, 8'h55, 1'b1);
    tx_q = '{8'hA5, 8'h30, 8'h01, 8'h55, 8'h7A};
    send_all();
    drain(4);
    checks++;
    if (ok_cnt - ok0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_frame got ok=%0d pending=%0d required ok=1 pending=0", ok_cnt - ok0, exp_q.size());
    end
    $display("test_reset_mid_write done");
  endtask

  task automatic test_back_to_back();
    int ok0, err0, n;
    logic [7:0] a, d, sum;
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q.push_back(8'h3C);
    for (int f = 0; f < 3; f++) begin
      a = 8'($urandom_range(0, 255));
      n = (f == 0) ? 16 : int'($urandom_range(1, 16));
      tx_q.push_back(SYNC);
      tx_q.push_back(a);
      tx_q.push_back(8'(n));
      sum = a + 8'(n);
      for (int i = 0; i < n; i++) begin
        d = (i == 1) ? SYNC : 8'($urandom_range(0, 255));
        tx_q.push_back(d);
        sum = sum + d;
        push_wr(a + 8'(i), d, (i == n - 1));
      end
      tx_q.push_back(8'h00 - sum);
    end
    send_all();
    drain(24);
    checks++;
    if (ok_cnt - ok0 != 3 || err_cnt != err0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back got ok=%0d errs=%0d pending=%0d required ok=3 errs=0 pending=0",
               ok_cnt - ok0, err_cnt - err0, exp_q.size());
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_addr_wrap();
    test_bad_len();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
